// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
// Holds scan-code set 2 prefix bytes, the receiver state encoding and the Pause skip length.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // Pause sends E1 followed by seven more bytes that never form a key event.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Key-event bundle from the PS/2 receiver toward the SoC keyboard PIO inputs.
// Everything is produced in the system clock domain.
interface ps2_keyboard_rx_if;
  logic [7:0] keycode;
  logic       press;
  logic       extended;
  logic       key_valid;
  logic       frame_err;

  modport master (output keycode, press, extended, key_valid, frame_err);
  modport slave  (input  keycode, press, extended, key_valid, frame_err);
endinterface

// File: rtl/ps2_byte_rx.sv
// PS/2 line conditioning and byte receiver: synchronisers, clock glitch filter,
// frame FSM with odd-parity/stop checks and an inactivity timeout.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// SHIFT  | collecting 8 data bits, LSB first
// PARITY | sampling the odd-parity bit
// STOP   | sampling the stop bit, then reporting byte or error
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       byte_rdy,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   clk_filt, fall;
  logic [FW-1:0]          filt_cnt;

  rx_state_t state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic          par_ok, par_ok_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          rdy_nxt, err_nxt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
        fall     <= ~clk_s;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_ok    <= 1'b0;
      tmo       <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_q   <= shift_nxt;
      par_ok    <= par_ok_nxt;
      tmo       <= tmo_nxt;
      byte_rdy  <= rdy_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    par_ok_nxt  = par_ok;
    tmo_nxt     = tmo;
    rdy_nxt     = 1'b0;
    err_nxt     = 1'b0;

    if (fall)
      tmo_nxt = '0;
    else if (state != IDLE)
      tmo_nxt = tmo + TW'(1);

    case (state)
      IDLE: begin
        if (fall && !dat_s) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          shift_nxt   = {dat_s, shift_q[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_ok_nxt = ^{shift_q, dat_s};
          state_nxt  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dat_s && par_ok)
            rdy_nxt = 1'b1;
          else
            err_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The pulse lands on the cycle the counter would read TIMEOUT_CYCLES.
    if (!fall && (state != IDLE) && (tmo == TMO_LAST)) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
      tmo_nxt   = '0;
    end
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 scan-code set 2 keyboard receiver: byte receiver plus prefix decoder
// turning make/break/E0 sequences into held key events with a one-cycle strobe.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PS2_CLK,
  input  logic              PS2_DAT,
  ps2_keyboard_rx_if.master key_if
);

  logic       byte_rdy, rx_err;
  logic [7:0] rx_byte;

  logic       brk, ext;
  logic [2:0] skip;
  logic [7:0] keycode_q;
  logic       press_q, extended_q, key_valid_q;

  ps2_byte_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_byte_rx (
    .Clk      (Clk),
    .Reset    (Reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .byte_rdy (byte_rdy),
    .rx_byte  (rx_byte),
    .frame_err(rx_err)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      skip        <= '0;
      keycode_q   <= '0;
      press_q     <= 1'b0;
      extended_q  <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (rx_err) begin
        brk  <= 1'b0;
        ext  <= 1'b0;
        skip <= '0;
      end else if (byte_rdy) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else if (rx_byte == PS2_PAUSE) begin
          skip <= PAUSE_SKIP;
          brk  <= 1'b0;
          ext  <= 1'b0;
        end else if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else if (!is_ignored(rx_byte)) begin
          keycode_q   <= rx_byte;
          press_q     <= ~brk;
          extended_q  <= ext;
          key_valid_q <= 1'b1;
          brk         <= 1'b0;
          ext         <= 1'b0;
        end
      end
    end
  end

  assign key_if.keycode   = keycode_q;
  assign key_if.press     = press_q;
  assign key_if.extended  = extended_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.frame_err = rx_err;

endmodule
